// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - I/O register bank: PIN/PORT/DDR per port, synchronised inputs, pin-change IRQs.
// Optional IO_PIN_TOGGLE_EN: writing a PIN address toggles the matching PORT bits.
module io_port_bank #(
    parameter int PORT_COUNT  = 3,
    parameter int PORT_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic                             write_en,
    input  logic [PORT_WIDTH-1:0]            write_data,
    input  logic                             read_en,
    output logic [PORT_WIDTH-1:0]            read_data,
    output logic                             read_valid,
    input  logic [PORT_COUNT*PORT_WIDTH-1:0] pins_in,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pins_out,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pins_dir,
    output logic [PORT_COUNT-1:0]            irq,
    output logic                             irq_any
);

    localparam int BW = PORT_COUNT * PORT_WIDTH;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] PRIME_DONE = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][BW-1:0] sync_q, sync_d;
    logic [BW-1:0]                  prev_q, prev_d;
    logic [BW-1:0]                  port_q, port_d;
    logic [BW-1:0]                  ddr_q, ddr_d;
    logic [BW-1:0]                  pcmsk_q, pcmsk_d;
    logic [PORT_COUNT-1:0]          pcifr_q, pcifr_d;
    logic [CW-1:0]                  prime_q, prime_d;
    logic [PORT_WIDTH-1:0]          read_data_q, read_data_d;
    logic                           read_valid_q, read_valid_d;

    logic [BW-1:0]                  pins_sync;
    logic [PORT_COUNT-1:0]          pc_set, pc_clear;
    logic [PORT_WIDTH-1:0]          rd_mux;

    assign pins_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pins_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d  = pins_sync;
        prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + CW'(1);
    end

    // Change detection stays off until the synchroniser and prev registers hold real pad values.
    always_comb begin
        pc_set = '0;
        for (int k = 0; k < PORT_COUNT; k++) begin
            pc_set[k] = (prime_q == PRIME_DONE) &&
                        (|((pins_sync[k*PORT_WIDTH +: PORT_WIDTH] ^ prev_q[k*PORT_WIDTH +: PORT_WIDTH])
                           & pcmsk_q[k*PORT_WIDTH +: PORT_WIDTH]));
        end
    end

    always_comb begin
        port_d   = port_q;
        ddr_d    = ddr_q;
        pcmsk_d  = pcmsk_q;
        pc_clear = '0;
        if (write_en) begin
            for (int k = 0; k < PORT_COUNT; k++) begin
`ifdef IO_PIN_TOGGLE_EN
                if (addr == ADDR_WIDTH'(3*k)) begin
                    port_d[k*PORT_WIDTH +: PORT_WIDTH] = port_q[k*PORT_WIDTH +: PORT_WIDTH] ^ write_data;
                end
`endif
                if (addr == ADDR_WIDTH'(3*k + 1)) begin
                    port_d[k*PORT_WIDTH +: PORT_WIDTH] = write_data;
                end
                if (addr == ADDR_WIDTH'(3*k + 2)) begin
                    ddr_d[k*PORT_WIDTH +: PORT_WIDTH] = write_data;
                end
                if (addr == ADDR_WIDTH'(3*PORT_COUNT + k)) begin
                    pcmsk_d[k*PORT_WIDTH +: PORT_WIDTH] = write_data;
                end
            end
            if (addr == ADDR_WIDTH'(4*PORT_COUNT)) begin
                pc_clear = write_data[PORT_COUNT-1:0];
            end
        end
        // A new edge beats a simultaneous write-1-to-clear.
        pcifr_d = (pcifr_q & ~pc_clear) | pc_set;
    end

    // Reads see pre-write register state, so read-during-write returns the old value.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < PORT_COUNT; k++) begin
            if (addr == ADDR_WIDTH'(3*k)) begin
                rd_mux = pins_sync[k*PORT_WIDTH +: PORT_WIDTH];
            end
            if (addr == ADDR_WIDTH'(3*k + 1)) begin
                rd_mux = port_q[k*PORT_WIDTH +: PORT_WIDTH];
            end
            if (addr == ADDR_WIDTH'(3*k + 2)) begin
                rd_mux = ddr_q[k*PORT_WIDTH +: PORT_WIDTH];
            end
            if (addr == ADDR_WIDTH'(3*PORT_COUNT + k)) begin
                rd_mux = pcmsk_q[k*PORT_WIDTH +: PORT_WIDTH];
            end
        end
        if (addr == ADDR_WIDTH'(4*PORT_COUNT)) begin
            rd_mux = PORT_WIDTH'(pcifr_q);
        end
        read_data_d  = read_en ? rd_mux : read_data_q;
        read_valid_d = read_en;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            prev_q       <= '0;
            port_q       <= '0;
            ddr_q        <= '0;
            pcmsk_q      <= '0;
            pcifr_q      <= '0;
            prime_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            port_q       <= port_d;
            ddr_q        <= ddr_d;
            pcmsk_q      <= pcmsk_d;
            pcifr_q      <= pcifr_d;
            prime_q      <= prime_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign pins_out   = port_q;
    assign pins_dir   = ddr_q;
    assign irq        = pcifr_q;
    assign irq_any    = |pcifr_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - scoreboard bench for io_port_bank with directed vectors.
module tb_io_port_bank;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  addr;
    logic        write_en;
    logic [7:0]  write_data;
    logic        read_en;
    logic [7:0]  read_data;
    logic        read_valid;
    logic [23:0] pins_in;
    logic [23:0] pins_out;
    logic [23:0] pins_dir;
    logic [2:0]  irq;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    io_port_bank dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .pins_in    (pins_in),
        .pins_out   (pins_out),
        .pins_dir   (pins_dir),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (reset_n && read_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read_valid read_data=%02h with no read pending", read_data);
            end else begin
                logic [7:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (read_data !== e) begin
                    errors++;
                    $display("FAIL %s read_data got %02h expected %02h", n, read_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; write_data = d; write_en = 1'b1;
        @(posedge clock); #1;
        write_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] e, input string n);
        addr = a; read_en = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clock); #1;
        read_en = 1'b0;
    endtask

    task automatic do_rw(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e, input string n);
        addr = a; write_data = d; write_en = 1'b1; read_en = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clock); #1;
        write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; addr = '0; write_en = 1'b0; write_data = '0; read_en = 1'b0; pins_in = '0;
        @(posedge clock); #1;
        cycles(2);
        check("reset_pins_out", pins_out, 24'h0);
        check("reset_pins_dir", pins_dir, 24'h0);
        check("reset_irq", {irq_any, irq}, 4'h0);
        check("reset_read_valid", read_valid, 1'b0);
        reset_n = 1'b1;
        cycles(5);

        do_write(8'h02, 8'hFF);
        do_write(8'h01, 8'hA5);
        check("ddrb", pins_dir[7:0], 8'hFF);
        check("portb", pins_out[7:0], 8'hA5);
        do_read(8'h01, 8'hA5, "read_portb");
        do_read(8'h02, 8'hFF, "read_ddrb");

        pins_in[15:8] = 8'h3C;
        do_read(8'h03, 8'h00, "pinc_stage0");
        do_read(8'h03, 8'h00, "pinc_stage1");
        do_read(8'h03, 8'h3C, "pinc_synced");

        do_write(8'h0A, 8'h01);
        do_read(8'h0A, 8'h01, "read_pcmsk1");
        pins_in[8] = 1'b1;
        cycles(4);
        check("irq_pin8", irq, 3'b010);
        check("irq_any_pin8", irq_any, 1'b1);
        do_read(8'h0C, 8'h02, "pcifr_set");
        do_write(8'h0C, 8'h02);
        check("irq_cleared", irq, 3'b000);
        pins_in[9] = 1'b1;
        cycles(4);
        check("irq_masked_pin9", {irq_any, irq}, 4'h0);
        do_read(8'h0C, 8'h00, "pcifr_masked");

        pins_in[8] = 1'b0;
        cycles(2);
        do_write(8'h0C, 8'h02);
        check("set_beats_clear", irq, 3'b010);
        do_write(8'h0C, 8'h02);
        check("clear_after_set", irq, 3'b000);

        do_read(8'h20, 8'h00, "unmapped_read");
        do_rw(8'h04, 8'h55, 8'h00, "rw_old_value");
        do_read(8'h04, 8'h55, "rw_new_value");
        check("portc", pins_out[15:8], 8'h55);
        do_write(8'h21, 8'hEE);
        check("unmapped_write", {pins_dir, pins_out}, {24'h0000FF, 24'h0055A5});

        do_write(8'h01, 8'h0F);
        do_write(8'h00, 8'hFF);
`ifdef IO_PIN_TOGGLE_EN
        check("pin_write_portb", pins_out[7:0], 8'hF0);
`else
        check("pin_write_portb", pins_out[7:0], 8'h0F);
`endif

        addr = 8'h01; read_en = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        write_en = 1'b1; write_data = 8'h77;
        pins_in = 24'hFFFFFF;
        #1;
        check("mid_read_reset_valid", read_valid, 1'b0);
        check("mid_reset_pins_out", pins_out, 24'h0);
        cycles(3);
        read_en = 1'b0; write_en = 1'b0;
        reset_n = 1'b1;
        #1;
        check("post_reset_valid", read_valid, 1'b0);
        @(posedge clock); #1;
        check("post_reset_write_discarded", pins_out, 24'h0);
        do_write(8'h09, 8'hFF);
        do_write(8'h0A, 8'hFF);
        do_write(8'h0B, 8'hFF);
        cycles(10);
        check("priming_no_flag", {irq_any, irq}, 4'h0);
        pins_in[0] = 1'b0;
        cycles(4);
        check("primed_flag_port0", {irq_any, irq}, 4'b1001);

        cycles(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
